// File: rtl/des_pkg.sv
// des_pkg: constants and types shared by the DES key path and round datapath.
//   PC1    : 56-entry permuted-choice-1 table (DES bit numbers, 1 = MSB of key)
//   PC2    : 48-entry permuted-choice-2 table (bit numbers into {C,D}, 1 = MSB)
//   SHIFTS : per-round left-rotate amounts, rounds 1..16
//   ks_state_e : key scheduler FSM states
package des_pkg;

  localparam int unsigned ROUND_KEY_W = 48;

  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int unsigned SHIFTS [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_e;

  // 28-bit circular rotates by 1 (two = 0) or 2 (two = 1)
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// des_pc2: combinational DES permuted-choice-2, 56 -> 48 bits.
//   cd_i  : {C,D}, bit 55 = PC-2 input bit 1
//   key_o : round subkey, bit 47 = PC-2 output bit 1
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0]            cd_i,
  output logic [ROUND_KEY_W-1:0] key_o
);

  for (genvar i = 0; i < 48; i++) begin : g_bit
    assign key_o[47-i] = cd_i[56-PC2[i]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES subkey generator with valid/next pacing.
//   CLK, RST  : rising-edge clock, asynchronous active-high reset
//   key_in    : 64-bit DES key (bit 63 = DES bit 1), sampled on accepted load
//   decrypt   : direction, sampled with load (0 = K1..K16, 1 = K16..K1)
//   load      : start request, honoured only in IDLE
//   next      : consumer has used the current subkey
//   round_key : current subkey (0 when key_valid = 0)
//   round_idx : index of subkey on round_key (Ki = idx+1)
//   key_valid : round_key/round_idx meaningful
//   busy      : schedule in progress
//   done      : one-cycle pulse after the 16th subkey is consumed
module des_key_schedule
  import des_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        load,
  input  logic        next,
  output logic [47:0] round_key,
  output logic [3:0]  round_idx,
  output logic        key_valid,
  output logic        busy,
  output logic        done
);

  ks_state_e   state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic        done_q, done_d;

  logic [55:0] pc1_cd;
  logic [15:0] shift2;     // bit r-1 set when SHIFTS[r] == 2
  logic [3:0]  sidx;
  logic [47:0] pc2_key;
  logic        unused_parity;

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_cd[55-i] = key_in[64-PC1[i]];
  end

  for (genvar r = 1; r <= 16; r++) begin : g_shift
    assign shift2[r-1] = (SHIFTS[r] == 2);
  end

  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  // Encrypt steps to round cnt+2 (mask bit cnt+1); decrypt undoes round
  // 16-cnt (mask bit 15-cnt, i.e. ~cnt).
  assign sidx = dir_q ? ~cnt_q : cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = RUN;
          cnt_d   = '0;
          dir_d   = decrypt;
          // C16/D16 equal C0/D0, so decrypt starts unrotated
          if (decrypt) begin
            c_d = pc1_cd[55:28];
            d_d = pc1_cd[27:0];
          end else begin
            c_d = rotl28(pc1_cd[55:28], shift2[0]);
            d_d = rotl28(pc1_cd[27:0], shift2[0]);
          end
        end
      end
      RUN: begin
        if (next) begin
          if (cnt_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (dir_q) begin
              c_d = rotr28(c_q, shift2[sidx]);
              d_d = rotr28(d_q, shift2[sidx]);
            end else begin
              c_d = rotl28(c_q, shift2[sidx]);
              d_d = rotl28(d_q, shift2[sidx]);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i  ({c_q, d_q}),
    .key_o (pc2_key)
  );

  always_comb begin
    key_valid = (state_q == RUN);
    busy      = (state_q == RUN);
    done      = done_q;
    round_key = key_valid ? pc2_key : '0;
    round_idx = '0;
    if (key_valid) round_idx = dir_q ? 4'd15 - cnt_q : cnt_q;
  end

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

  logic        CLK = 1'b0;
  logic        RST;
  logic [63:0] key_in;
  logic        decrypt;
  logic        load;
  logic        next;
  logic [47:0] round_key;
  logic [3:0]  round_idx;
  logic        key_valid;
  logic        busy;
  logic        done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic        v;
    logic [3:0]  idx;
    logic [47:0] key;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sb[$];

  localparam int T_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int T_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int T_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_schedule dut (
    .CLK       (CLK),
    .RST       (RST),
    .key_in    (key_in),
    .decrypt   (decrypt),
    .load      (load),
    .next      (next),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Reference subkey Ki (round = 1..16) from cumulative rotation of C0/D0
  function automatic logic [47:0] model_key(input logic [63:0] key, input int round);
    logic [55:0] cd;
    logic [63:0] s64;
    logic [55:0] s56;
    logic [27:0] c, d;
    logic [47:0] k;
    int tot;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      s64 = key >> (64 - T_PC1[i]);
      cd  = {cd[54:0], s64[0]};
    end
    c = cd[55:28];
    d = cd[27:0];
    tot = 0;
    for (int r = 0; r < round; r++) tot += T_SH[r];
    for (int s = 0; s < tot; s++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    k = '0;
    for (int i = 0; i < 48; i++) begin
      s56 = {c, d} >> (56 - T_PC2[i]);
      k   = {k[46:0], s56[0]};
    end
    return k;
  endfunction

  function automatic exp_t mk(input logic v, input int idx, input logic [47:0] k,
                              input logic b, input logic dn);
    exp_t e;
    e.v    = v;
    e.idx  = 4'(idx);
    e.key  = k;
    e.busy = b;
    e.done = dn;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_key"},   64'(round_key), 64'd0);
    chk({tag, "_idx"},   64'(round_idx), 64'd0);
    chk({tag, "_valid"}, 64'(key_valid), 64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_done"},  64'(done),      64'd0);
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then
  // pop and compare after the edge.
  task automatic cyc(input logic ld, input logic nx, input logic [63:0] k,
                     input logic dec, input exp_t e);
    exp_t x;
    load    = ld;
    next    = nx;
    key_in  = k;
    decrypt = dec;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    x = sb.pop_front();
    chk("key",   64'(round_key), 64'(x.key));
    chk("idx",   64'(round_idx), 64'(x.idx));
    chk("valid", 64'(key_valid), 64'(x.v));
    chk("busy",  64'(busy),      64'(x.busy));
    chk("done",  64'(done),      64'(x.done));
  endtask

  // Full schedule with next held high; gold adds checks of the published
  // K1/K16 values for key 0x133457799BBCDFF1.
  task automatic sched(input logic [63:0] k, input logic dec, input logic gold);
    int rk;
    rk = dec ? 16 : 1;
    cyc(1'b1, 1'b0, k, dec, mk(1'b1, rk - 1, model_key(k, rk), 1'b1, 1'b0));
    if (gold) chk("gold_first", 64'(round_key), dec ? 64'hCB3D8B0E17F5 : 64'h1B02EFFC7072);
    for (int r = 1; r < 16; r++) begin
      rk = dec ? 16 - r : r + 1;
      cyc(1'b0, 1'b1, k, dec, mk(1'b1, rk - 1, model_key(k, rk), 1'b1, 1'b0));
    end
    if (gold) chk("gold_last", 64'(round_key), dec ? 64'h1B02EFFC7072 : 64'hCB3D8B0E17F5);
    cyc(1'b0, 1'b1, k, dec, mk(1'b0, 0, 48'h0, 1'b0, 1'b1));
  endtask

  localparam logic [63:0] GOLD_KEY = 64'h133457799BBCDFF1;

  initial begin
    logic [63:0] key2;
    logic [63:0] key3;
    key2    = {$urandom, $urandom};
    key3    = {$urandom, $urandom};
    RST     = 1'b1;
    load    = 1'b0;
    next    = 1'b0;
    decrypt = 1'b0;
    key_in  = '0;
    #12;
    chk_idle("reset");
    @(negedge CLK);
    RST = 1'b0;

    // next while idle is ignored
    cyc(1'b0, 1'b1, GOLD_KEY, 1'b0, mk(1'b0, 0, 48'h0, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, GOLD_KEY, 1'b0, mk(1'b0, 0, 48'h0, 1'b0, 1'b0));

    // encrypt and decrypt with the reference key
    sched(GOLD_KEY, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, GOLD_KEY, 1'b0, mk(1'b0, 0, 48'h0, 1'b0, 1'b0));
    sched(GOLD_KEY, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, GOLD_KEY, 1'b0, mk(1'b0, 0, 48'h0, 1'b0, 1'b0));

    // stall five cycles on K3
    cyc(1'b1, 1'b0, key2, 1'b0, mk(1'b1, 0, model_key(key2, 1), 1'b1, 1'b0));
    cyc(1'b0, 1'b1, key2, 1'b0, mk(1'b1, 1, model_key(key2, 2), 1'b1, 1'b0));
    cyc(1'b0, 1'b1, key2, 1'b0, mk(1'b1, 2, model_key(key2, 3), 1'b1, 1'b0));
    for (int s = 0; s < 5; s++)
      cyc(1'b0, 1'b0, key2, 1'b0, mk(1'b1, 2, model_key(key2, 3), 1'b1, 1'b0));
    for (int r = 4; r <= 16; r++)
      cyc(1'b0, 1'b1, key2, 1'b0, mk(1'b1, r - 1, model_key(key2, r), 1'b1, 1'b0));
    cyc(1'b0, 1'b1, key2, 1'b0, mk(1'b0, 0, 48'h0, 1'b0, 1'b1));
    cyc(1'b0, 1'b0, key2, 1'b0, mk(1'b0, 0, 48'h0, 1'b0, 1'b0));

    // load while busy: ignored, alone or together with next
    cyc(1'b1, 1'b0, key2, 1'b0, mk(1'b1, 0, model_key(key2, 1), 1'b1, 1'b0));
    cyc(1'b1, 1'b0, key3, 1'b1, mk(1'b1, 0, model_key(key2, 1), 1'b1, 1'b0));
    for (int r = 2; r <= 16; r++)
      cyc(1'b1, 1'b1, key3, 1'b1, mk(1'b1, r - 1, model_key(key2, r), 1'b1, 1'b0));
    cyc(1'b1, 1'b1, key3, 1'b1, mk(1'b0, 0, 48'h0, 1'b0, 1'b1));
    cyc(1'b0, 1'b0, key3, 1'b0, mk(1'b0, 0, 48'h0, 1'b0, 1'b0));

    // asynchronous reset after K7
    cyc(1'b1, 1'b0, GOLD_KEY, 1'b0, mk(1'b1, 0, model_key(GOLD_KEY, 1), 1'b1, 1'b0));
    for (int r = 2; r <= 7; r++)
      cyc(1'b0, 1'b1, GOLD_KEY, 1'b0, mk(1'b1, r - 1, model_key(GOLD_KEY, r), 1'b1, 1'b0));
    next = 1'b0;
    #3;
    RST = 1'b1;
    #1;
    chk_idle("async_rst");
    @(negedge CLK);
    RST = 1'b0;
    cyc(1'b0, 1'b0, GOLD_KEY, 1'b0, mk(1'b0, 0, 48'h0, 1'b0, 1'b0));
    cyc(1'b1, 1'b0, key3, 1'b0, mk(1'b1, 0, model_key(key3, 1), 1'b1, 1'b0));
    for (int r = 2; r <= 16; r++)
      cyc(1'b0, 1'b1, key3, 1'b0, mk(1'b1, r - 1, model_key(key3, r), 1'b1, 1'b0));
    cyc(1'b0, 1'b1, key3, 1'b0, mk(1'b0, 0, 48'h0, 1'b0, 1'b1));

    // back-to-back: load in the done cycle, then an all-zero key
    sched(key2, 1'b1, 1'b0);
    sched(64'h0, 1'b0, 1'b0);
    sched(key3, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, key3, 1'b0, mk(1'b0, 0, 48'h0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
